// File: rtl/lp_inverse.sv
// Inverse of the first-order IIR low-pass smoother: rebuilds the narrow input sample from the filtered stream.
// Optional build macro LP_INV_ROUND_EN selects round-half-up on the inverse-gain shift instead of floor.
module lp_inverse #(
    parameter int IN_W      = 24,
    parameter int OUT_W     = 12,
    parameter int INV_NUM   = 12428,
    parameter int INV_SHIFT = 7,
    parameter int NUM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_sat
);
    localparam int STAGES = 3;
    localparam int DIFF_W = IN_W + 1;
    localparam int PROD_W = IN_W + 1 + NUM_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [PROD_W-1:0] INV_S = PROD_W'(INV_NUM);
    localparam logic signed [SUM_W-1:0]  MAXV  = SUM_W'((1 << OUT_W) - 1);
`ifdef LP_INV_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND   = PROD_W'(1 << (INV_SHIFT - 1));
`endif

    typedef struct packed {
        logic signed [DIFF_W-1:0] diff;
        logic [IN_W-1:0]          y;
    } s1_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] corr;
        logic [IN_W-1:0]          y;
    } s2_t;

    logic [STAGES:1]          vld_pipe;
    logic                     adv;
    logic                     in_xfer;
    logic [IN_W-1:0]          y_prev;
    s1_t                      st1;
    s2_t                      st2;
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] corr_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [OUT_W-1:0]         sat_data;
    logic                     sat_flag;

    assign m_valid = vld_pipe[STAGES];
    assign adv     = !m_valid | m_ready;
    assign s_ready = adv & !clr & rst_n;
    assign in_xfer = s_valid & s_ready;

    // Zero-extended operands so the difference of two unsigned samples is exact.
    assign diff_c = $signed({1'b0, s_data}) - $signed({1'b0, y_prev});
    assign prod_c = PROD_W'($signed(st1.diff)) * INV_S;

`ifdef LP_INV_ROUND_EN
    assign corr_c = (prod_c + RND) >>> INV_SHIFT;
`else
    assign corr_c = prod_c >>> INV_SHIFT;
`endif

    assign sum_c = SUM_W'($signed(st2.corr)) + SUM_W'($signed({1'b0, st2.y}));

    always_comb begin
        sat_data = sum_c[OUT_W-1:0];
        sat_flag = 1'b0;
        if (sum_c < 0) begin
            sat_data = '0;
            sat_flag = 1'b1;
        end else if (sum_c > MAXV) begin
            sat_data = '1;
            sat_flag = 1'b1;
        end
    end

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            y_prev   <= '0;
            st1      <= '0;
            st2      <= '0;
            m_data   <= '0;
            m_sat    <= 1'b0;
        end else if (clr) begin
            vld_pipe <= '0;
            y_prev   <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_xfer};
            if (in_xfer) begin
                st1.diff <= diff_c;
                st1.y    <= y_prev;
                y_prev   <= s_data;
            end
            st2.corr <= corr_c;
            st2.y    <= st1.y;
            m_data   <= sat_data;
            m_sat    <= sat_flag;
        end
    end
endmodule

// File: tb/tb_lp_inverse.sv
// Randomized and directed bench for lp_inverse against a queue-based arithmetic reference model.
module tb_lp_inverse;
    localparam int IN_W      = 24;
    localparam int OUT_W     = 12;
    localparam int INV_NUM   = 12428;
    localparam int INV_SHIFT = 7;
    localparam int NUM_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [IN_W-1:0]  s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [OUT_W-1:0] m_data;
    logic             m_sat;

    int vectors = 0;
    int miscompares = 0;

    logic [OUT_W:0] exp_q[$];
    logic [OUT_W:0] got_q[$];
    logic [OUT_W:0] ref_q[$];
    longint         yprev = 0;
    logic           stall_pend = 1'b0;
    logic [OUT_W+1:0] stall_snap;
    logic           last_acc;

    lp_inverse #(
        .IN_W(IN_W), .OUT_W(OUT_W), .INV_NUM(INV_NUM), .INV_SHIFT(INV_SHIFT), .NUM_W(NUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
    );

    always #5 clk = ~clk;

    // x_est = y_prev + floor-or-round((y - y_prev) * INV_NUM / 2^INV_SHIFT), clamped to the output range.
    function automatic logic [OUT_W:0] ref_out(input longint y, input longint yp);
        longint p, c, s, den, maxv;
        den  = longint'(1) << INV_SHIFT;
        maxv = (longint'(1) << OUT_W) - 1;
        p = (y - yp) * INV_NUM;
`ifdef LP_INV_ROUND_EN
        p = p + den / 2;
`endif
        if (p >= 0) c = p / den;
        else        c = -((-p + den - 1) / den);
        s = c + yp;
        if (s < 0)         return {1'b1, OUT_W'(0)};
        else if (s > maxv) return {1'b1, OUT_W'(maxv)};
        else               return {1'b0, OUT_W'(s)};
    endfunction

    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic r, input logic c, input logic rs);
        logic exp_rdy, acc, oxf;
        logic [OUT_W:0] e;
        s_valid = v; s_data = d; m_ready = r; clr = c; rst_n = rs;
        @(negedge clk);
        exp_rdy = rs & !c & (!m_valid | r);
        vectors++;
        if (s_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL s_ready: got %b want %b (m_valid=%b m_ready=%b clr=%b rst_n=%b)", s_ready, exp_rdy, m_valid, r, c, rs);
        end
        if (stall_pend) begin
            vectors++;
            if ({m_valid, m_sat, m_data} !== stall_snap) begin
                miscompares++;
                $display("FAIL stall_hold: got %h want %h", {m_valid, m_sat, m_data}, stall_snap);
            end
        end
        acc = v & exp_rdy;
        oxf = rs & (m_valid === 1'b1) & r;
        if (oxf) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_out: got data %0d sat %b want no output", m_data, m_sat);
            end else begin
                e = exp_q.pop_front();
                if ({m_sat, m_data} !== e) begin
                    miscompares++;
                    $display("FAIL out_data: got %0d sat %b want %0d sat %b", m_data, m_sat, e[OUT_W-1:0], e[OUT_W]);
                end
            end
            got_q.push_back({m_sat, m_data});
        end
        stall_pend = rs & !c & (m_valid === 1'b1) & !r;
        stall_snap = {m_valid, m_sat, m_data};
        @(posedge clk);
        #1;
        if (!rs || c) begin
            exp_q.delete();
            yprev = 0;
        end else if (acc) begin
            exp_q.push_back(ref_out(longint'(d), yprev));
            yprev = longint'(d);
        end
        last_acc = acc;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && m_valid !== 1'b1) break;
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        end
        vectors++;
        if (exp_q.size() != 0 || m_valid === 1'b1) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        got_q.delete();
    endtask

    task automatic check_out(input string name, input int idx, input int dat, input logic sat);
        vectors++;
        if (idx >= got_q.size()) begin
            miscompares++;
            $display("FAIL %s: got no output #%0d want %0d sat %b", name, idx, dat, sat);
        end else if (got_q[idx] !== {sat, OUT_W'(dat)}) begin
            miscompares++;
            $display("FAIL %s: got %0d sat %b want %0d sat %b", name, got_q[idx][OUT_W-1:0], got_q[idx][OUT_W], dat, sat);
        end
    endtask

    task automatic check_latency_42(input string name);
        int lat;
        int want;
`ifdef LP_INV_ROUND_EN
        want = 4078;
`else
        want = 4077;
`endif
        got_q.delete();
        cyc(1'b1, 24'd42, 1'b1, 1'b0, 1'b1);
        lat = 1;
        while (m_valid !== 1'b1 && lat < 10) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
            lat++;
        end
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want 3", name, lat);
        end
        drain();
        check_out(name, 0, want, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 24'd5, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({m_valid, m_data, m_sat} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: got v=%b d=%0d s=%b want all 0", m_valid, m_data, m_sat);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_single();
        do_reset();
        check_latency_42("single42");
    endtask

    task automatic test_const();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 24'd1000, 1'b1, 1'b0, 1'b1);
        drain();
        check_out("const0", 0, 4095, 1'b1);
        for (int i = 1; i < 4; i++) check_out("const", i, 1000, 1'b0);
    endtask

    task automatic test_step_down();
        do_reset();
        cyc(1'b1, 24'd100, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 24'd0, 1'b1, 1'b0, 1'b1);
        drain();
        check_out("step_hi", 0, 4095, 1'b1);
        check_out("step_lo", 1, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0] samp[8];
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int i, k;
        for (int j = 0; j < 8; j++) samp[j] = IN_W'(2000 + $urandom_range(0, 300));
        do_reset();
        for (int j = 0; j < 8; j++) cyc(1'b1, samp[j], 1'b1, 1'b0, 1'b1);
        drain();
        ref_q = got_q;
        do_reset();
        i = 0; k = 0;
        while (i < 8 && k < 100) begin
            cyc(1'b1, samp[i], pat[k % 4], 1'b0, 1'b1);
            if (last_acc) i++;
            k++;
        end
        while ((exp_q.size() != 0 || m_valid === 1'b1) && k < 200) begin
            cyc(1'b0, '0, pat[k % 4], 1'b0, 1'b1);
            k++;
        end
        vectors++;
        if (got_q.size() != 8 || ref_q.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count: got %0d/%0d want 8", got_q.size(), ref_q.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                vectors++;
                if (got_q[j] !== ref_q[j]) begin
                    miscompares++;
                    $display("FAIL bp_order: got %h want %h at %0d", got_q[j], ref_q[j], j);
                end
            end
        end
    endtask

    task automatic test_clr();
        do_reset();
        cyc(1'b1, 24'd42, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 24'd84, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 24'd99, 1'b1, 1'b1, 1'b1);
        drain();
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL clr_flush: got %0d outputs want 1", got_q.size());
        end
        check_out("clr_first", 0, 4077, 1'b0);
        check_latency_42("clr_restart");
    endtask

    task automatic test_rst_mid();
        int n;
        do_reset();
        cyc(1'b1, 24'd300, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 24'd310, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        vectors++;
        if (m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_fill: got m_valid %b want 1", m_valid);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({m_valid, m_data, m_sat} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outs: got v=%b d=%0d s=%b want all 0", m_valid, m_data, m_sat);
        end
        check_latency_42("rst_mid");
    endtask

    task automatic test_random();
        logic [IN_W-1:0] base;
        logic [IN_W-1:0] d;
        do_reset();
        base = 24'd2000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) d = IN_W'($urandom);
            else begin
                d = IN_W'(int'(base) + $urandom_range(0, 20) - 10);
                base = d;
            end
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 150) != 0);
            if (!rst_n || clr) base = 24'd2000;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_const();
        test_step_down();
        test_back_to_back();
        test_clr();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lp_inverse.md
Name: lp_inverse

Overview:
- Inverse of the first-order IIR low-pass smoother used in the sensor path, y[n] = y[n-1] + (x[n]-y[n-1])*ALPHA/2^SHIFT.
- Takes the filtered wide stream and reconstructs an estimate of the original narrow input sample: x_est[n] = y[n-1] + (y[n]-y[n-1])*INV_NUM/2^INV_SHIFT.
- Sits downstream of the smoother for loopback self-test and calibration.
- 3-stage pipeline with valid/ready handshake on both sides, saturation to the narrow range, and a per-sample saturation flag.

Parameters:
- IN_W, 24: width of filtered input sample (unsigned).
- OUT_W, 12: width of reconstructed output sample (unsigned).
- INV_NUM, 12428: inverse-gain numerator. Equals round(2^SHIFT*2^INV_SHIFT/ALPHA) for ALPHA=1350, SHIFT=17.
- INV_SHIFT, 7: inverse-gain denominator is 2^INV_SHIFT.
- NUM_W, 16: width of INV_NUM (unsigned).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- clr  in  1  synchronous history clear and pipeline flush
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept input this cycle
- s_data  in  IN_W  filtered sample y[n]
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  OUT_W  reconstructed sample x_est[n]
- m_sat  out  1  m_data was clipped (qualified by m_valid)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - m_valid=0, m_data=0, m_sat=0.
  - All stage valids 0.
  - y_prev=0 (matches smoother reset state).
  - s_ready is 0 during reset.
- Transfers: an input transfer occurs when s_valid&s_ready; an output transfer when m_valid&m_ready.
- Advance condition: adv = !m_valid | m_ready. s_ready = adv & !clr & rst_n. All stages shift together only when adv=1; otherwise hold (m_data stable while m_valid=1 and m_ready=0).
- Stage 1, on input transfer:
  - diff = signed(s_data) - signed(y_prev), width IN_W+1, zero-extended operands.
  - Register diff and y_prev; then y_prev <= s_data.
  - y_prev updates only on an input transfer.
- Stage 2:
  - prod = diff * INV_NUM, signed, width IN_W+1+NUM_W+1, no overflow.
  - corr = prod >>> INV_SHIFT (arithmetic, floor).
- Stage 3:
  - sum = corr + y_prev_d (signed, one guard bit).
  - If sum < 0: m_data=0, m_sat=1.
  - Else if sum > 2^OUT_W-1: m_data=2^OUT_W-1, m_sat=1.
  - Else: m_data=sum[OUT_W-1:0], m_sat=0.
- Latency: 3 cycles from input transfer to m_valid with m_ready held 1. Throughput 1 sample/cycle. Bubbles propagate as invalid stages.
- Backpressure: with m_valid=1 and m_ready=0, the whole pipe stalls and s_ready=0. No sample is dropped or duplicated.
- clr=1 (rst_n=1):
  - Next edge: y_prev=0; stage valids and m_valid cleared.
  - In-flight samples are discarded; s_valid in the same cycle is not accepted (s_ready=0).
  - Data registers may hold stale values.
- Simultaneous events:
  - rst_n=0 overrides clr.
  - clr overrides handshakes.
  - Input and output transfers in the same cycle are legal.
- Reset mid-stream: all in-flight samples are lost and y_prev returns to 0. The first post-reset sample is differenced against 0.

Optional Feature:
- Macro: LP_INV_ROUND_EN.
- Defined: Stage 2 uses corr = (prod + 2^(INV_SHIFT-1)) >>> INV_SHIFT (round half up).
- Undefined: plain arithmetic shift (floor).
- Latency, handshake and saturation rules are identical in both builds.

Test Plan:
- Reset, then s_data=42, m_ready=1 → after 3 cycles m_data=4077, m_sat=0. With LP_INV_ROUND_EN: 4078.
- Constant s_data=1000 for 4 samples after reset → first output 4095 with m_sat=1 (step from 0), then 1000,1000,1000 with m_sat=0.
- Samples 100 then 0 after reset → outputs 4095 (sat=1), then 0 (sat=1; sum=-9610).
- Stream of 8 samples with m_ready toggled 1,0,0,1,... → every input appears exactly once, in order, with values equal to the no-stall run. s_ready=0 in every cycle with m_valid=1 and m_ready=0.
- Stream 42,84 then clr during the cycle the second sample is in stage 2 → the second output is never produced. The next sample 42 yields 4077, i.e. history restarted from 0.
- rst_n=0 for one cycle mid-stream with m_valid=1 → next cycle m_valid=0, m_data=0, m_sat=0. The next input 42 yields 4077 after 3 cycles.
